// File: rtl/data_ram_arbiter_pkg.sv
// data_ram_arbiter_pkg
//   Shared types and widths for the data_ram arbiter slice.
//   - arb_state_e  : lock FSM states (ARB_IDLE, ARB_LOCK1)
//   - arb_master_e : grant encodings (ARB_M0 = CPU, ARB_M1 = DMA/debug)
//   - bus widths matching the DataBus / DataAddressBus of the min SOPC
package data_ram_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_LOCK1 = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_master_e;

  localparam int unsigned DATA_BUS_W      = 32;
  localparam int unsigned DATA_ADDR_BUS_W = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned LOCK_CNT_W      = 8;

endpackage

// File: rtl/dram_arb_lock_ctr.sv
// dram_arb_lock_ctr
//   Lock FSM for M1 back-to-back ownership with a bounded hold time.
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous reset, active-low
//     enter  in   M1 granted with lock requested while idle
//     hold   in   M1 still requests the lock (m1_lock_i)
//     locked out  FSM is in LOCK1 (M1 owns the RAM this cycle)
//   lock_cnt counts owned cycles starting at 1 on entry; the lock is
//   released when hold drops or lock_cnt reaches MAX_LOCK.
module dram_arb_lock_ctr
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic hold,
  output logic locked
);

  arb_state_e              state, state_next;
  logic [LOCK_CNT_W-1:0]   lock_cnt, lock_cnt_next;
  logic                    timeout;

  assign timeout = (lock_cnt == LOCK_CNT_W'(MAX_LOCK));
  assign locked  = (state == ARB_LOCK1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Exit always lands in IDLE, so re-entry needs at least one IDLE cycle.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (enter) begin
          state_next    = ARB_LOCK1;
          lock_cnt_next = LOCK_CNT_W'(1);
        end
      end
      ARB_LOCK1: begin
        if (!hold || timeout) begin
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + LOCK_CNT_W'(1);
        end
      end
      default: begin
        state_next    = ARB_IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port data_ram between M0 (CPU memory stage) and
//   M1 (DMA/debug loader). Grant is combinational; accesses complete in
//   the granted cycle. M1 may lock the RAM for up to MAX_LOCK cycles.
//   Ports:
//     clk, rst                         clock, synchronous active-low reset
//     m0_req_i/we_i/addr_i/sel_i/data_i   M0 request fields
//     m0_data_o, m0_stall_o            M0 read data, stall (pending, not granted)
//     m1_req_i/we_i/addr_i/sel_i/data_i   M1 request fields
//     m1_lock_i                        M1 back-to-back ownership request
//     m1_gnt_o, m1_data_o              M1 grant, read data
//     ram_ce_o/we_o/addr_o/sel_o/data_o   muxed access to data_ram
//     ram_data_i                       data_ram combinational read data
//   Build option: ARB_ROUND_ROBIN_EN selects round-robin contention in
//   IDLE; otherwise M0 has fixed priority.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned DW       = DATA_BUS_W,
  parameter int unsigned AW       = DATA_ADDR_BUS_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req_i,
  input  logic             m0_we_i,
  input  logic [AW-1:0]    m0_addr_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [DW-1:0]    m0_data_i,
  output logic [DW-1:0]    m0_data_o,
  output logic             m0_stall_o,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  logic [AW-1:0]    m1_addr_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [DW-1:0]    m1_data_i,
  input  logic             m1_lock_i,
  output logic             m1_gnt_o,
  output logic [DW-1:0]    m1_data_o,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [SEL_W-1:0] ram_sel_o,
  output logic [DW-1:0]    ram_data_o,
  input  logic [DW-1:0]    ram_data_i
);

  logic gnt0, gnt1;
  logic locked;

`ifdef ARB_ROUND_ROBIN_EN
  // Only M1 can be granted while locked, so a lock exit already leaves
  // last_gnt at M1. The fixed-priority build has no reader for it.
  arb_master_e last_gnt;

  always_ff @(posedge clk) begin
    if (!rst)      last_gnt <= ARB_M1;
    else if (gnt0) last_gnt <= ARB_M0;
    else if (gnt1) last_gnt <= ARB_M1;
  end
`endif

  dram_arb_lock_ctr #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_ctr (
    .clk   (clk),
    .rst   (rst),
    .enter (gnt1 & m1_lock_i & ~locked),
    .hold  (m1_lock_i),
    .locked(locked)
  );

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (locked) begin
        gnt1 = m1_req_i;
      end else if (m0_req_i && m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_gnt == ARB_M1) gnt0 = 1'b1;
        else                    gnt1 = 1'b1;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (gnt0) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m0_we_i;
      ram_addr_o = m0_addr_i;
      ram_sel_o  = m0_sel_i;
      ram_data_o = m0_data_i;
    end else if (gnt1) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = m1_we_i;
      ram_addr_o = m1_addr_i;
      ram_sel_o  = m1_sel_i;
      ram_data_o = m1_data_i;
    end
  end

  assign m0_data_o  = gnt0 ? ram_data_i : '0;
  assign m1_data_o  = gnt1 ? ram_data_i : '0;
  assign m1_gnt_o   = gnt1;
  assign m0_stall_o = rst & m0_req_i & ~gnt0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a cycle-level behavioural model of the arbitration rules and
//   a model memory. A small byte-lane RAM stands in for data_ram.
module tb_data_ram_arbiter;

  localparam int unsigned MAX_LOCK = 8;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_stall, m1_gnt;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  data_ram_arbiter #(
    .DW(32),
    .AW(32),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_data_i(m0_wdata), .m0_data_o(m0_rdata), .m0_stall_o(m0_stall),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_data_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_data_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Stand-in data_ram: combinational read, byte-lane write on the edge.
  logic [31:0] ram [16];
  assign ram_rdata = ram[ram_addr[5:2]];
  always @(posedge clk)
    if (ram_ce && ram_we) ram[ram_addr[5:2]] <= merge(ram[ram_addr[5:2]], ram_wdata, ram_sel);

  // Reference model state
  logic [31:0] mdl_mem [16];
  bit          mdl_locked;
  int          mdl_held;
  int          mdl_last;
  bit          last_g0, last_g1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Evaluate one clock cycle: check outputs, then advance the model.
  task automatic cycle();
    bit          g0, g1;
    logic [3:0]  i0, i1;
    logic [31:0] a, s, d, w;
    #1;
    g0 = 0;
    g1 = 0;
    if (rst) begin
      if (mdl_locked) g1 = m1_req;
      else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        g0 = (mdl_last == 1);
        g1 = !g0;
`else
        g0 = 1;
`endif
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
    i0 = m0_addr[5:2];
    i1 = m1_addr[5:2];
    a = g0 ? m0_addr  : (g1 ? m1_addr  : 32'd0);
    s = g0 ? {28'd0, m0_sel} : (g1 ? {28'd0, m1_sel} : 32'd0);
    d = g0 ? m0_wdata : (g1 ? m1_wdata : 32'd0);
    w = g0 ? {31'd0, m0_we} : (g1 ? {31'd0, m1_we} : 32'd0);

    check_eq("ram_ce",   {31'd0, ram_ce},   {31'd0, (g0 | g1)});
    check_eq("m1_gnt",   {31'd0, m1_gnt},   {31'd0, g1});
    check_eq("m0_stall", {31'd0, m0_stall}, {31'd0, (rst & m0_req & !g0)});
    check_eq("ram_we",   {31'd0, ram_we},   w);
    check_eq("ram_addr", ram_addr,          a);
    check_eq("ram_sel",  {28'd0, ram_sel},  s);
    check_eq("ram_wdata", ram_wdata,        d);
    check_eq("m0_rdata", m0_rdata, g0 ? mdl_mem[i0] : 32'd0);
    check_eq("m1_rdata", m1_rdata, g1 ? mdl_mem[i1] : 32'd0);

    if (!rst) begin
      mdl_locked = 0;
      mdl_held   = 0;
      mdl_last   = 1;
    end else begin
      if (mdl_locked) begin
        if (!m1_lock || mdl_held == MAX_LOCK) begin
          mdl_locked = 0;
          mdl_held   = 0;
        end else begin
          mdl_held++;
        end
      end else if (g1 && m1_lock) begin
        mdl_locked = 1;
        mdl_held   = 1;
      end
      if (g0) mdl_last = 0;
      if (g1) mdl_last = 1;
      if (g0 && m0_we) mdl_mem[i0] = merge(mdl_mem[i0], m0_wdata, m0_sel);
      if (g1 && m1_we) mdl_mem[i1] = merge(mdl_mem[i1], m1_wdata, m1_sel);
    end
    last_g0 = g0;
    last_g1 = g1;
    @(negedge clk);
  endtask

  task automatic new_m0();
    m0_req   = ($urandom_range(0, 99) < 60);
    m0_we    = 1'($urandom_range(0, 1));
    m0_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    m0_sel   = 4'($urandom_range(1, 15));
    m0_wdata = $urandom;
  endtask

  task automatic new_m1();
    m1_req   = ($urandom_range(0, 99) < 60);
    m1_we    = 1'($urandom_range(0, 1));
    m1_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    m1_sel   = 4'($urandom_range(1, 15));
    m1_wdata = $urandom;
  endtask

  int m1_count;

  initial begin
    for (int k = 0; k < 16; k++) begin
      ram[k]     = '0;
      mdl_mem[k] = '0;
    end
    mdl_locked = 0; mdl_held = 0; mdl_last = 1;
    last_g0 = 0; last_g1 = 0;
    rst = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_sel = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_sel = '0; m1_wdata = '0; m1_lock = 0;
    @(negedge clk);

    // Reset held with both masters requesting, then first contention
    m0_req = 1; m1_req = 1;
    for (int n = 0; n < 3; n++) cycle();
    rst = 1;
    cycle();

    // M0 alone: write then read back
    m1_req = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'hDEADBEEF;
    cycle();
    m0_we = 0; m0_wdata = '0;
    #1 check_eq("m0_readback", m0_rdata, 32'hDEADBEEF);
    check_eq("m0_readback_stall", {31'd0, m0_stall}, 32'd0);
    cycle();

    // Six cycles of contention without lock
    m0_req = 1; m0_we = 0; m0_addr = 32'h4;
    m1_req = 1; m1_we = 0; m1_addr = 32'h8; m1_lock = 0;
    m1_count = 0;
    for (int n = 0; n < 6; n++) begin
      #1 m1_count += int'(m1_gnt);
      cycle();
    end
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("contention_m1_grants", m1_count, 3);
`else
    check_eq("contention_m1_grants", m1_count, 0);
`endif

    // M1 lock held for 20 cycles while M0 keeps requesting
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_sel = 4'hF;
    for (int n = 0; n < 20; n++) begin
      if (last_g1) begin m1_addr = {26'd0, 4'(n), 2'b00}; m1_wdata = $urandom; end
      if (last_g0) m0_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      cycle();
    end

    // Lock entered with M0 idle, dropped after 3 locked cycles
    m1_lock = 0; m1_req = 0; m0_req = 0;
    cycle();
    m1_req = 1; m1_lock = 1; m1_we = 0;
    cycle();
    m0_req = 1; m0_we = 0;
    for (int n = 0; n < 3; n++) cycle();
    m1_lock = 0;
    for (int n = 0; n < 3; n++) cycle();

    // Reset during a lock with an M1 write pending
    m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_sel = 4'hF; m0_wdata = 32'h12345678;
    cycle();
    m0_req = 0; m0_we = 0;
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 32'h0;
    for (int n = 0; n < 3; n++) cycle();
    m1_we = 1; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'hA5A5A5A5;
    rst = 0;
    cycle();
    rst = 1; m1_req = 0; m1_lock = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    #1 check_eq("reset_blocks_write", m0_rdata, 32'h12345678);
    cycle();

    // Randomized traffic with occasional reset pulses
    m0_req = 0; m1_req = 0;
    for (int n = 0; n < 600; n++) begin
      if (!m0_req || last_g0) new_m0();
      if (!m1_req || last_g1) new_m1();
      if ($urandom_range(0, 99) < 15) m1_lock = ~m1_lock;
      rst = ($urandom_range(0, 99) >= 2);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
